// File: rtl/normalize_and_pack.sv
// normalize_and_pack: post-add stage of the FP32 adder.
// It takes the sign, the tentative exponent, the raw 24-bit mantissa and the carry from align+add.
// It normalizes one step per cycle: a single right shift on carry, or left shifts while leading zeros remain.
// It handles the zero, overflow and subnormal cases, then packs an IEEE-754 single with truncation rounding.
module normalize_and_pack #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 24
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             S_In,
    input  logic [EXP_W-1:0] E_In,
    input  logic [MAN_W-1:0] M_In,
    input  logic             Carry_In,
    output logic             Busy,
    output logic             Done,
    output logic [31:0]      Result,
    output logic             Zero,
    output logic             Overflow,
    output logic             Underflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        PACK = 2'd2
    } state_t;

    state_t             state_r, state_nx_s;
    logic               s_r, s_nx_s;
    // One extra exponent bit so that the carry increment past 255 is visible as overflow.
    logic [EXP_W:0]     e_r, e_nx_s;
    logic [MAN_W-1:0]   m_r, m_nx_s;
    logic               c_r, c_nx_s;
    logic               busy_r, busy_nx_s;
    logic               done_r, done_nx_s;
    logic [31:0]        result_r, result_nx_s;
    logic               zero_r, zero_nx_s;
    logic               ovf_r, ovf_nx_s;
    logic               unf_r, unf_nx_s;

    // Next-state, datapath and packed-output decisions for the IDLE/NORM/PACK sequence.
    always_comb begin
        state_nx_s  = state_r;
        s_nx_s      = s_r;
        e_nx_s      = e_r;
        m_nx_s      = m_r;
        c_nx_s      = c_r;
        done_nx_s   = 1'b0;
        result_nx_s = result_r;
        zero_nx_s   = zero_r;
        ovf_nx_s    = ovf_r;
        unf_nx_s    = unf_r;
        case (state_r)
            IDLE: begin
                if (Start) begin
                    s_nx_s     = S_In;
                    e_nx_s     = {1'b0, E_In};
                    m_nx_s     = M_In;
                    c_nx_s     = Carry_In;
                    state_nx_s = NORM;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            NORM: begin
                if (c_r) begin
                    // The carry-out becomes the new hidden bit; the LSB is truncated.
                    m_nx_s     = {1'b1, m_r[MAN_W-1:1]};
                    e_nx_s     = e_r + {{EXP_W{1'b0}}, 1'b1};
                    c_nx_s     = 1'b0;
                    state_nx_s = PACK;
                end else if (m_r == {MAN_W{1'b0}}) begin
                    state_nx_s = PACK;
                end else if (m_r[MAN_W-1] || (e_r <= {{EXP_W{1'b0}}, 1'b1})) begin
                    // Either normalized or the exponent floor is reached, which leaves a subnormal.
                    state_nx_s = PACK;
                end else begin
                    m_nx_s     = {m_r[MAN_W-2:0], 1'b0};
                    e_nx_s     = e_r - {{EXP_W{1'b0}}, 1'b1};
                    state_nx_s = NORM;
                end
            end
            PACK: begin
                done_nx_s  = 1'b1;
                state_nx_s = IDLE;
                zero_nx_s  = 1'b0;
                ovf_nx_s   = 1'b0;
                unf_nx_s   = 1'b0;
                if (m_r == {MAN_W{1'b0}}) begin
                    // An exact cancellation always gives +0.
                    result_nx_s = 32'h0000_0000;
                    zero_nx_s   = 1'b1;
                end else if (e_r >= {1'b0, {EXP_W{1'b1}}}) begin
                    result_nx_s = {s_r, 8'hFF, 23'h00_0000};
                    ovf_nx_s    = 1'b1;
                end else if (!m_r[MAN_W-1] && (e_r <= {{EXP_W{1'b0}}, 1'b1})) begin
                    result_nx_s = {s_r, 8'h00, m_r[22:0]};
                    unf_nx_s    = 1'b1;
                end else begin
                    result_nx_s = {s_r, e_r[7:0], m_r[22:0]};
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
        busy_nx_s = (state_nx_s != IDLE);
    end

    // State, work registers and registered outputs; an async reset aborts any job in flight.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r  <= IDLE;
            s_r      <= 1'b0;
            e_r      <= {(EXP_W+1){1'b0}};
            m_r      <= {MAN_W{1'b0}};
            c_r      <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= 32'h0000_0000;
            zero_r   <= 1'b0;
            ovf_r    <= 1'b0;
            unf_r    <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            s_r      <= s_nx_s;
            e_r      <= e_nx_s;
            m_r      <= m_nx_s;
            c_r      <= c_nx_s;
            busy_r   <= busy_nx_s;
            done_r   <= done_nx_s;
            result_r <= result_nx_s;
            zero_r   <= zero_nx_s;
            ovf_r    <= ovf_nx_s;
            unf_r    <= unf_nx_s;
        end
    end

    assign Busy      = busy_r;
    assign Done      = done_r;
    assign Result    = result_r;
    assign Zero      = zero_r;
    assign Overflow  = ovf_r;
    assign Underflow = unf_r;

endmodule
